// File: rtl/clkdiv_pkg.sv
// ==== clkdiv_pkg : shared FSM encoding and ratio limits for clkdiv_ratio_ctrl ====
// ==== Rev 1.0 ====
`default_nettype none

package clkdiv_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WAIT_LOW = 3'd2,
        ST_HOLD     = 3'd3,
        ST_ACK      = 3'd4
    } state_e;

    localparam int MIN_RATIO = 2;

endpackage

`default_nettype wire

// File: rtl/clkdiv_rr_arb.sv
// ==== clkdiv_rr_arb : combinational round-robin pick, lowest index at/after ptr_i ====
// ==== Rev 1.0 ====
`default_nettype none

module clkdiv_rr_arb #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  winner_o,
    output logic             valid_o
);

    logic [NREQ-1:0] w_rot;
    logic [NREQ-1:0] w_pick;
    logic [PTR_W:0]  w_rshift;

    // Rotate so the pointer slot sits at bit 0, pick the lowest set bit, rotate back.
    assign w_rot    = NREQ'({req_i, req_i} >> ptr_i);
    assign w_rshift = (PTR_W + 1)'(NREQ) - {1'b0, ptr_i};

    always_comb begin
        w_pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pick    = '0;
                w_pick[i] = 1'b1;
            end
        end
    end

    assign winner_o = NREQ'({w_pick, w_pick} >> w_rshift);
    assign valid_o  = |req_i;

endmodule

`default_nettype wire

// File: rtl/clkdiv_ratio_ctrl.sv
// ==== clkdiv_ratio_ctrl : arbitrated, glitch-safe ratio changes for a shared divider ====
// ==== Rev 1.0 -- optional macro CLKDIV_CTRL_SAME_SKIP_EN skips reloads of an unchanged ratio ====
`default_nettype none

module clkdiv_ratio_ctrl
    import clkdiv_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int RATIO_W       = 32,
    parameter int DEFAULT_RATIO = 2,
    parameter int SETTLE_CYC    = 2
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*RATIO_W-1:0]   req_ratio,
    input  logic                      div_clk,
    output logic                      div_reset,
    output logic [RATIO_W-1:0]        div_ratio,
    output logic [NREQ-1:0]           grant,
    output logic                      err,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]      win_q, win_d;
    logic [RATIO_W-1:0]   ratio_q, ratio_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 div_reset_q, div_reset_d;
    logic [RATIO_W-1:0]   div_ratio_q, div_ratio_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic [NREQ-1:0]      w_arb_win;
    logic                 w_arb_valid;
    logic [RATIO_W-1:0]   w_sel_ratio;
    logic [RATIO_W-1:0]   w_sel_even;
    logic [PTR_W-1:0]     w_win_idx;
    logic [PTR_W-1:0]     w_ptr_next;

    clkdiv_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (w_arb_win),
        .valid_o  (w_arb_valid)
    );

    always_comb begin
        w_sel_ratio = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_win[i]) w_sel_ratio = req_ratio[i*RATIO_W +: RATIO_W];
        end
    end

    // The divider halves the ratio internally, so only even values are ever loaded.
    assign w_sel_even = {w_sel_ratio[RATIO_W-1:1], 1'b0};

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q[i]) w_win_idx = PTR_W'(i);
        end
    end

    assign w_ptr_next = (w_win_idx == PTR_W'(NREQ - 1)) ? '0 : w_win_idx + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        ratio_d     = ratio_q;
        cnt_d       = cnt_q;
        div_reset_d = div_reset_q;
        div_ratio_d = div_ratio_q;
        grant_d     = '0;
        err_d       = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                state_d     = ST_IDLE;
                div_reset_d = 1'b0;
            end
            ST_IDLE: begin
                if (w_arb_valid) begin
                    win_d   = w_arb_win;
                    ratio_d = w_sel_even;
                    if (w_sel_ratio < RATIO_W'(MIN_RATIO)) begin
                        state_d = ST_ACK;
                        grant_d = w_arb_win;
                        err_d   = 1'b1;
                    end
`ifdef CLKDIV_CTRL_SAME_SKIP_EN
                    else if (w_sel_even == div_ratio_q) begin
                        state_d = ST_ACK;
                        grant_d = w_arb_win;
                    end
`endif
                    else begin
                        state_d = ST_WAIT_LOW;
                    end
                end
            end
            ST_WAIT_LOW: begin
                // Only touch the divider while its output is low so no runt pulse escapes.
                if (!div_clk) begin
                    state_d     = ST_HOLD;
                    div_reset_d = 1'b1;
                    div_ratio_d = ratio_q;
                    cnt_d       = CNT_W'(SETTLE_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d     = ST_ACK;
                    div_reset_d = 1'b0;
                    grant_d     = win_q;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                ptr_d   = w_ptr_next;
            end
            default: state_d = ST_INIT;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            win_q       <= '0;
            ratio_q     <= RATIO_W'(DEFAULT_RATIO);
            cnt_q       <= '0;
            div_reset_q <= 1'b1;
            div_ratio_q <= RATIO_W'(DEFAULT_RATIO);
            grant_q     <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            ratio_q     <= ratio_d;
            cnt_q       <= cnt_d;
            div_reset_q <= div_reset_d;
            div_ratio_q <= div_ratio_d;
            grant_q     <= grant_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign div_reset = div_reset_q;
    assign div_ratio = div_ratio_q;
    assign grant     = grant_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_clkdiv_ratio_ctrl.sv
// ==== tb_clkdiv_ratio_ctrl : timeline-model and directed checks for clkdiv_ratio_ctrl ====
// ==== Rev 1.0 ====
`default_nettype none
`timescale 1ns/1ps

module tb_clkdiv_ratio_ctrl;

    localparam int NREQ = 4;
    localparam int RW   = 32;
    localparam int DEF  = 2;
    localparam int S    = 2;

    logic                 clk_in    = 1'b0;
    logic                 reset_n   = 1'b0;
    logic                 div_clk   = 1'b0;
    logic [NREQ-1:0]      req       = '0;
    logic [NREQ*RW-1:0]   req_ratio = '0;
    logic                 div_reset;
    logic [RW-1:0]        div_ratio;
    logic [NREQ-1:0]      grant;
    logic                 err;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    clkdiv_ratio_ctrl #(
        .NREQ          (NREQ),
        .RATIO_W       (RW),
        .DEFAULT_RATIO (DEF),
        .SETTLE_CYC    (S)
    ) dut (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .req       (req),
        .req_ratio (req_ratio),
        .div_clk   (div_clk),
        .div_reset (div_reset),
        .div_ratio (div_ratio),
        .grant     (grant),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Transaction timeline model: each change is a start cycle, the cycle div_clk was
    // seen low, and the grant cycle; outputs follow from those timestamps.
    logic            e_rst;
    logic [RW-1:0]   e_ratio;
    logic [NREQ-1:0] e_gnt;
    logic            e_err;
    logic            e_busy;
    int              cyc;
    bit              tx_on, tx_err, tx_short, found;
    int              tx_n, tx_low, tx_gnt, tx_win, idx, m_ptr, k;
    logic [RW-1:0]   tx_ratio, m_ratio, r;

    initial begin : model
        forever begin
            @(posedge clk_in or negedge reset_n);
            if (!reset_n) begin
                cyc = 0; tx_on = 1'b0; m_ratio = DEF; m_ptr = 0;
                e_rst = 1'b1; e_ratio = DEF; e_gnt = '0; e_err = 1'b0; e_busy = 1'b1;
            end else begin
                k = cyc;
                cyc++;
                if (tx_on) begin
                    if (!tx_short && tx_low < 0 && k > tx_n && !div_clk) begin
                        tx_low = k;
                        tx_gnt = k + S + 1;
                    end
                    if (k == tx_gnt) begin
                        tx_on = 1'b0;
                        m_ptr = (tx_win + 1) % NREQ;
                    end
                end else if (k >= 1 && req != '0) begin
                    found = 1'b0;
                    tx_win = 0;
                    for (int off = 0; off < NREQ; off++) begin
                        idx = (m_ptr + off) % NREQ;
                        if (!found && req[idx]) begin
                            found  = 1'b1;
                            tx_win = idx;
                        end
                    end
                    r        = req_ratio[tx_win*RW +: RW];
                    tx_on    = 1'b1;
                    tx_n     = k;
                    tx_low   = -1;
                    tx_gnt   = -1;
                    tx_err   = (r < 2);
                    tx_ratio = r & ~32'd1;
                    tx_short = tx_err;
`ifdef CLKDIV_CTRL_SAME_SKIP_EN
                    if (!tx_err && tx_ratio == m_ratio) tx_short = 1'b1;
`endif
                    if (tx_short) tx_gnt = k + 1;
                end
                e_gnt = '0;
                if (tx_on && tx_gnt == k + 1) e_gnt[tx_win] = 1'b1;
                e_err = tx_on && (tx_gnt == k + 1) && tx_err;
                if (tx_on && tx_low >= 0 && k == tx_low) m_ratio = tx_ratio;
                e_rst   = tx_on && tx_low >= 0 && (k + 1 > tx_low) && (k + 1 <= tx_low + S);
                e_ratio = m_ratio;
                e_busy  = tx_on;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_in);
            if (chk_en) begin
                check("m_div_reset", {31'd0, div_reset}, {31'd0, e_rst});
                check("m_div_ratio", div_ratio, e_ratio);
                check("m_grant", {28'd0, grant}, {28'd0, e_gnt});
                check("m_err", {31'd0, err}, {31'd0, e_err});
                check("m_busy", {31'd0, busy}, {31'd0, e_busy});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic raise(input int i, input logic [RW-1:0] ratio);
        req[i] = 1'b1;
        req_ratio[i*RW +: RW] = ratio;
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g, output logic e, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (grant == '0 && lat < 40);
        if (grant == '0) check("grant_timeout", 32'd0, 32'd1);
        g = grant;
        e = err;
    endtask

    logic [NREQ-1:0] g;
    logic            e;
    int              lat;

    initial begin : stim
        repeat (2) tick();
        chk_en = 1'b1;
        check("rst_div_reset", {31'd0, div_reset}, 32'd1);
        check("rst_div_ratio", div_ratio, 32'd2);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_grant", {28'd0, grant}, 32'd0);
        reset_n = 1'b1;
        #3;
        check("init_div_reset", {31'd0, div_reset}, 32'd1);
        check("init_div_ratio", div_ratio, 32'd2);
        tick();
        check("idle_div_reset", {31'd0, div_reset}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Accepted change, divider output already low.
        raise(1, 32'd10);
        tick(); tick();
        check("t2_ratio_n2", div_ratio, 32'd10);
        check("t2_reset_n2", {31'd0, div_reset}, 32'd1);
        tick();
        check("t2_reset_n3", {31'd0, div_reset}, 32'd1);
        tick();
        check("t2_grant_n4", {28'd0, grant}, 32'h2);
        check("t2_err_n4", {31'd0, err}, 32'd0);
        req[1] = 1'b0;
        tick();
        check("t2_reset_after", {31'd0, div_reset}, 32'd0);

        // Rejected ratio: answered next cycle, divider untouched.
        raise(0, 32'd1);
        tick();
        check("t3_grant", {28'd0, grant}, 32'h1);
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_ratio", div_ratio, 32'd10);
        check("t3_reset", {31'd0, div_reset}, 32'd0);
        req[0] = 1'b0;
        tick();
        raise(3, 32'd0);
        tick();
        check("t3b_grant", {28'd0, grant}, 32'h8);
        req[3] = 1'b0;
        tick();

        // Simultaneous requests with pointer back at 0.
        raise(0, 32'd4);
        raise(2, 32'd12);
        wait_grant(g, e, lat);
        check("t4_first", {28'd0, g}, 32'h1);
        check("t4_first_lat", lat, 32'd4);
        req[0] = 1'b0;
        tick();
        raise(0, 32'd4);
        wait_grant(g, e, lat);
        check("t4_second", {28'd0, g}, 32'h4);
        req[2] = 1'b0;
        tick();
        wait_grant(g, e, lat);
        check("t4_third", {28'd0, g}, 32'h1);
        req[0] = 1'b0;
        tick();

        // Odd ratio, divider output high for five cycles.
        div_clk = 1'b1;
        raise(1, 32'd7);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_wait_reset", {31'd0, div_reset}, 32'd0);
            check("t5_wait_ratio", div_ratio, 32'd4);
            check("t5_wait_busy", {31'd0, busy}, 32'd1);
        end
        div_clk = 1'b0;
        tick();
        check("t5_hold_ratio", div_ratio, 32'd6);
        check("t5_hold_reset", {31'd0, div_reset}, 32'd1);
        wait_grant(g, e, lat);
        check("t5_grant", {28'd0, g}, 32'h2);
        req[1] = 1'b0;
        tick();

        // Reset during HOLD.
        raise(3, 32'd20);
        tick(); tick();
        check("t6_in_hold", {31'd0, div_reset}, 32'd1);
        reset_n = 1'b0;
        req     = '0;
        #1;
        check("t6_rst_ratio", div_ratio, 32'd2);
        check("t6_rst_reset", {31'd0, div_reset}, 32'd1);
        check("t6_rst_grant", {28'd0, grant}, 32'd0);
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("t6_no_grant", {28'd0, grant}, 32'd0);
        end

        // Request for the ratio already loaded.
        raise(0, 32'd2);
`ifdef CLKDIV_CTRL_SAME_SKIP_EN
        tick();
        check("t7_skip_grant", {28'd0, grant}, 32'h1);
        check("t7_skip_err", {31'd0, err}, 32'd0);
        check("t7_skip_reset", {31'd0, div_reset}, 32'd0);
`else
        wait_grant(g, e, lat);
        check("t7_full_grant", {28'd0, g}, 32'h1);
        check("t7_full_lat", lat, 32'd4);
`endif
        req[0] = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
